// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM state
// encoding and the request legality check used at accept time.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_ISSUE = 3'd1,
    S_LD_CAPT  = 3'd2,
    S_RMW_RD   = 3'd3,
    S_RMW_MRG  = 3'd4,
    S_ST_WR    = 3'd5,
    S_RESP     = 3'd6
  } lsu_state_e;

  // A request is rejected for an unknown width, a sign-variant store, a
  // misaligned halfword/word or an address beyond the end of data memory.
  function automatic logic lsu_illegal(input logic            store,
                                       input logic [2:0]      f3,
                                       input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] limit);
    logic bad;
    bad = (addr >= limit);
    case (f3)
      F3_B, F3_BU: bad = bad;
      F3_H, F3_HU: bad = bad | addr[0];
      F3_W:        bad = bad | (addr[1:0] != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (store && f3[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// The slave modport is the unit itself; master is the CPU + memory side.
interface load_store_unit_if;

  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_store;
  logic [2:0]                           req_funct3;
  logic [load_store_unit_pkg::XLEN-1:0] req_addr;
  logic [load_store_unit_pkg::XLEN-1:0] req_wdata;

  logic                                 resp_valid;
  logic [load_store_unit_pkg::XLEN-1:0] resp_rdata;
  logic                                 resp_err;

  logic                                 mem_read;
  logic                                 mem_write;
  logic [load_store_unit_pkg::XLEN-1:0] data_addr;
  logic [load_store_unit_pkg::XLEN-1:0] write_data;
  logic [load_store_unit_pkg::XLEN-1:0] read_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, data_addr, write_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, data_addr, write_data
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte/halfword lane logic: extract+extend a loaded word, and merge store data
// into a previously read word for sub-word read-modify-write.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [15:0]     wdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_data,
  output logic [XLEN-1:0] merged
);

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    byte_s   = byte_sel;
    half_s   = half_sel;

    ext_data = word;
    case (funct3)
      F3_B:    ext_data = XLEN'(byte_s);
      F3_H:    ext_data = XLEN'(half_s);
      F3_BU:   ext_data = {24'h0, byte_sel};
      F3_HU:   ext_data = {16'h0, half_sel};
      default: ext_data = word;
    endcase
  end

  // Only the addressed lane changes; every other byte keeps the value just read.
  always_comb begin
    merged = word;
    if (funct3 == F3_B) begin
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      if (lane[1]) merged[31:16] = wdata;
      else         merged[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one CPU load/store at a time onto a word-wide data
// memory, with sub-word access, read-modify-write stores and request checking.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int DEBUG     = 0
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  localparam logic [XLEN-1:0] AddrLimit = 32'(MEM_WORDS * 4);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            store_q;
  logic            err_q;

  logic            resp_valid_q;
  logic            resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;

  logic            accept;
  logic            req_illegal;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] merged_data;

  assign accept      = bus.req_valid && (state_q == S_IDLE);
  assign req_illegal = lsu_illegal(bus.req_store, bus.req_funct3, bus.req_addr, AddrLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal)                 state_d = S_RESP;
          else if (!bus.req_store)         state_d = S_LD_ISSUE;
          else if (bus.req_funct3 == F3_W) state_d = S_ST_WR;
          else                             state_d = S_RMW_RD;
        end
      end
      S_LD_ISSUE: state_d = S_LD_CAPT;
      S_LD_CAPT:  state_d = S_RESP;
      S_RMW_RD:   state_d = S_RMW_MRG;
      S_RMW_MRG:  state_d = S_ST_WR;
      S_ST_WR:    state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  load_store_unit_align u_align (
    .word     (bus.read_data),
    .wdata    (wdata_q[15:0]),
    .lane     (addr_q[1:0]),
    .funct3   (funct3_q),
    .ext_data (ext_data),
    .merged   (merged_data)
  );

  // wdata_q doubles as the load staging register, so resp_rdata only moves
  // together with resp_valid and otherwise holds the previous load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= (state_q == S_RESP);
      if (accept) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
        store_q  <= bus.req_store;
        err_q    <= req_illegal;
      end
      if (state_q == S_LD_CAPT) wdata_q <= ext_data;
      if (state_q == S_RMW_MRG) wdata_q <= merged_data;
      if (state_q == S_RESP) begin
        resp_err_q <= err_q;
        if (!err_q && !store_q) resp_rdata_q <= wdata_q;
      end
    end
  end

  // Memory strobes decode straight from the state so reset drops them at once.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_read   = (state_q == S_LD_ISSUE) || (state_q == S_RMW_RD);
  assign bus.mem_write  = (state_q == S_ST_WR);
  assign bus.data_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus.write_data = wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  if (DEBUG != 0) begin : g_debug
    always_ff @(posedge clk) begin
      if (!reset) assert (!(bus.mem_read && bus.mem_write));
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit paired with a registered-read data memory model;
// vector table plus reset-abort and back-to-back sequences, scoreboard-checked.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int MEM_WORDS = 32;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .DEBUG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_rdata = 32'h0;

  int compared   = 0;
  int mismatched = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, acc_cnt = 0, resp_cnt = 0;

  // Data memory: read_data is registered one cycle after mem_read.
  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hCAFEF00D;
      mem[3] <= 32'h11223344;
    end else begin
      if (bus.mem_read)  bus.read_data <= mem[bus.data_addr[6:2]];
      if (bus.mem_write) mem[bus.data_addr[6:2]] <= bus.write_data;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_read)                  rd_cnt   <= rd_cnt + 1;
    if (bus.mem_write)                 wr_cnt   <= wr_cnt + 1;
    if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
    if (!reset && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("resp_err[%0d]", mon_e.id), {31'b0, bus.resp_err}, {31'b0, mon_e.err});
        chk($sformatf("resp_rdata[%0d]", mon_e.id), bus.resp_rdata, mon_e.rdata);
        chk($sformatf("resp_latency[%0d]", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  function automatic void add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er; v.lat = lat;
    tbl.push_back(v);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int id, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit hold);
    int   n;
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk($sformatf("accept_timeout[%0d]", id), 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (!st && !exp_err) model_rdata = exp_rd;
    e.id = id; e.rdata = model_rdata; e.err = exp_err; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, rc0, ac0;

    add(1'b1, F3_W,  32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    add(1'b0, F3_W,  32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 3);
    add(1'b1, F3_B,  32'h09, 32'h00000055, 32'h0,        1'b0, 4);
    add(1'b0, F3_B,  32'h09, 32'h0,        32'h00000055, 1'b0, 3);
    add(1'b0, F3_BU, 32'h0B, 32'h0,        32'h000000DE, 1'b0, 3);
    add(1'b0, F3_B,  32'h0B, 32'h0,        32'hFFFFFFDE, 1'b0, 3);
    add(1'b1, F3_H,  32'h0E, 32'h00008001, 32'h0,        1'b0, 4);
    add(1'b0, F3_H,  32'h0E, 32'h0,        32'hFFFF8001, 1'b0, 3);
    add(1'b0, F3_HU, 32'h0E, 32'h0,        32'h00008001, 1'b0, 3);
    add(1'b0, F3_W,  32'h0C, 32'h0,        32'h80013344, 1'b0, 3);
    add(1'b0, F3_W,  32'h06, 32'h0,        32'h0,        1'b1, 1);
    add(1'b1, F3_H,  32'h03, 32'h1234,     32'h0,        1'b1, 1);
    add(1'b0, 3'b011, 32'h00, 32'h0,       32'h0,        1'b1, 1);
    add(1'b0, F3_W,  32'h80, 32'h0,        32'h0,        1'b1, 1);
    add(1'b1, F3_BU, 32'h10, 32'h000000AA, 32'h0,        1'b1, 1);
    add(1'b0, 3'b110, 32'h10, 32'h0,       32'h0,        1'b1, 1);
    add(1'b1, F3_W,  32'h7C, 32'h12345678, 32'h0,        1'b0, 2);
    add(1'b0, F3_BU, 32'h7F, 32'h0,        32'h00000012, 1'b0, 3);
    add(1'b0, F3_B,  32'h80, 32'h0,        32'h0,        1'b1, 1);

    reset          = 1'b1;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;

    chk("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset_resp_err",   {31'b0, bus.resp_err},   32'd0);
    chk("reset_mem_read",   {31'b0, bus.mem_read},   32'd0);
    chk("reset_mem_write",  {31'b0, bus.mem_write},  32'd0);
    chk("reset_req_ready",  {31'b0, bus.req_ready},  32'd1);

    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue(i, tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, tbl[i].lat, 1'b0);
      drain();
      if (tbl[i].err) begin
        chk($sformatf("err_no_mem_read[%0d]", i),  32'(rd_cnt - rd0), 32'd0);
        chk($sformatf("err_no_mem_write[%0d]", i), 32'(wr_cnt - wr0), 32'd0);
      end
    end

    chk("mem_word2_after_sb", mem[2],  32'hDEAD55EF);
    chk("mem_word3_after_sh", mem[3],  32'h80013344);
    chk("mem_word31_sw",      mem[31], 32'h12345678);

    // Reset during RMW_MRG of SB @0x04: the write must never be issued.
    wr0 = wr_cnt;
    rc0 = resp_cnt;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h04;
    bus.req_wdata  = 32'h000000AA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_mem_write_in_reset", {31'b0, bus.mem_write}, 32'd0);
    chk("abort_mem_read_in_reset",  {31'b0, bus.mem_read},  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'h0;
    @(posedge clk);
    #1;
    chk("abort_ready_first_edge", {31'b0, bus.req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_no_mem_write", 32'(wr_cnt - wr0),   32'd0);
    chk("abort_no_resp",      32'(resp_cnt - rc0), 32'd0);
    chk("abort_word1_kept",   mem[1],              32'hCAFEF00D);
    chk("abort_rdata_cleared", bus.resp_rdata,     32'd0);

    issue(50, 1'b0, F3_W, 32'h04, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0);
    drain();

    // Back-to-back with req_valid held high between requests.
    rc0 = resp_cnt;
    ac0 = acc_cnt;
    issue(100, 1'b0, F3_W,  32'h08, 32'h0,        32'hDEAD55EF, 1'b0, 3, 1'b1);
    issue(101, 1'b1, F3_W,  32'h10, 32'h0BADF00D, 32'h0,        1'b0, 2, 1'b1);
    issue(102, 1'b0, F3_W,  32'h10, 32'h0,        32'h0BADF00D, 1'b0, 3, 1'b1);
    issue(103, 1'b0, F3_H,  32'h01, 32'h0,        32'h0,        1'b1, 1, 1'b1);
    issue(104, 1'b0, F3_BU, 32'h10, 32'h0,        32'h0000000D, 1'b0, 3, 1'b0);
    drain();
    chk("b2b_accepts",   32'(acc_cnt - ac0),  32'd5);
    chk("b2b_responses", 32'(resp_cnt - rc0), 32'd5);

    chk("never_read_and_write", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
